// File: rtl/weather_feature_sequencer_if.sv
// Raw sensor beat handshake between a reading producer (master) and the feature sequencer (slave).
interface weather_feature_sequencer_if;
  logic       raw_valid;
  logic       raw_ready;
  logic [1:0] raw_field;
  logic [7:0] raw_data;

  modport master (output raw_valid, output raw_field, output raw_data, input raw_ready);
  modport slave  (input raw_valid, input raw_field, input raw_data, output raw_ready);
endinterface

// File: rtl/weather_feature_sequencer.sv
// Quantizes raw weather beats into a 4-field feature vector and presents it to the decision tree.
// Optional partial-vector idle timeout is enabled by defining WEATHER_FEATURE_SEQ_TIMEOUT_EN.
module weather_feature_sequencer #(
  parameter int TEMP_OFFSET  = 8,
  parameter int TEMP_SHIFT   = 2,
  parameter int PRECIP_SHIFT = 0,
  parameter int WIND_SHIFT   = 1,
  parameter int HOLD_CYCLES  = 8
`ifdef WEATHER_FEATURE_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT      = 16
`endif
) (
  input  logic                      CLOCK_50,
  input  logic                      rst,
  weather_feature_sequencer_if.slave raw,
  output logic [3:0]                in_temp_max,
  output logic [3:0]                in_temp_min,
  output logic [3:0]                in_precipitation,
  output logic [3:0]                in_wind,
  output logic                      feat_valid,
  output logic                      tree_rst,
  output logic                      vec_done,
  output logic [7:0]                vec_count,
  output logic                      err_timeout
);

  typedef enum logic [1:0] {IDLE, COLLECT, PRESENT, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0][3:0] feat_q, feat_d;
  logic [3:0]      mask_q, mask_d;
  logic [7:0]      hold_q, hold_d;
  logic [7:0]      vec_count_q, vec_count_d;
  logic            raw_ready_q, raw_ready_d;
  logic            feat_valid_q, feat_valid_d;
  logic            tree_rst_q, tree_rst_d;
  logic            vec_done_q, vec_done_d;
  logic            accept;
  logic [3:0]      mask_merged;

`ifdef WEATHER_FEATURE_SEQ_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              err_timeout_q, err_timeout_d;
`endif

  // Temperatures are biased signed values clamped at 0; the other fields are plain unsigned scales.
  function automatic logic [3:0] quantize(input logic [1:0] field, input logic [7:0] data);
    logic [9:0] biased;
    logic [9:0] scaled;
    biased = 10'($signed({{2{data[7]}}, data}) + TEMP_OFFSET);
    case (field)
      2'd0, 2'd1: scaled = biased[9] ? 10'd0 : (biased >> TEMP_SHIFT);
      2'd2:       scaled = {2'b00, data} >> PRECIP_SHIFT;
      default:    scaled = {2'b00, data} >> WIND_SHIFT;
    endcase
    return (scaled > 10'd15) ? 4'hF : scaled[3:0];
  endfunction

  assign accept      = raw.raw_valid && raw_ready_q;
  assign mask_merged = mask_q | (4'b0001 << raw.raw_field);

  always_comb begin
    state_d     = state_q;
    feat_d      = feat_q;
    mask_d      = mask_q;
    hold_d      = hold_q;
    vec_count_d = vec_count_q;
    tree_rst_d  = 1'b0;
    vec_done_d  = 1'b0;
`ifdef WEATHER_FEATURE_SEQ_TIMEOUT_EN
    idle_d        = idle_q;
    err_timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: state_d = COLLECT;
      COLLECT: begin
        if (accept) begin
          feat_d[raw.raw_field] = quantize(raw.raw_field, raw.raw_data);
          mask_d                = mask_merged;
          if (mask_merged == 4'b1111) begin
            state_d    = PRESENT;
            hold_d     = 8'd1;
            tree_rst_d = 1'b1;
          end
        end
`ifdef WEATHER_FEATURE_SEQ_TIMEOUT_EN
        if (accept) begin
          idle_d = '0;
        end else if (mask_q != 4'b0000) begin
          if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
            mask_d        = 4'b0000;
            idle_d        = '0;
            err_timeout_d = 1'b1;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
`endif
      end
      PRESENT: begin
        if (hold_q == 8'(HOLD_CYCLES)) begin
          state_d     = DONE;
          vec_done_d  = 1'b1;
          vec_count_d = vec_count_q + 8'd1;
          mask_d      = 4'b0000;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      DONE:    state_d = COLLECT;
      default: state_d = IDLE;
    endcase
    // Outputs follow the next state so they are registered yet aligned with the state they describe.
    raw_ready_d  = (state_d == COLLECT);
    feat_valid_d = (state_d == PRESENT);
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q      <= IDLE;
      feat_q       <= '0;
      mask_q       <= '0;
      hold_q       <= '0;
      vec_count_q  <= '0;
      raw_ready_q  <= 1'b0;
      feat_valid_q <= 1'b0;
      tree_rst_q   <= 1'b0;
      vec_done_q   <= 1'b0;
`ifdef WEATHER_FEATURE_SEQ_TIMEOUT_EN
      idle_q        <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      feat_q       <= feat_d;
      mask_q       <= mask_d;
      hold_q       <= hold_d;
      vec_count_q  <= vec_count_d;
      raw_ready_q  <= raw_ready_d;
      feat_valid_q <= feat_valid_d;
      tree_rst_q   <= tree_rst_d;
      vec_done_q   <= vec_done_d;
`ifdef WEATHER_FEATURE_SEQ_TIMEOUT_EN
      idle_q        <= idle_d;
      err_timeout_q <= err_timeout_d;
`endif
    end
  end

  assign raw.raw_ready      = raw_ready_q;
  assign in_temp_max        = feat_q[0];
  assign in_temp_min        = feat_q[1];
  assign in_precipitation   = feat_q[2];
  assign in_wind            = feat_q[3];
  assign feat_valid         = feat_valid_q;
  assign tree_rst           = tree_rst_q;
  assign vec_done           = vec_done_q;
  assign vec_count          = vec_count_q;
`ifdef WEATHER_FEATURE_SEQ_TIMEOUT_EN
  assign err_timeout        = err_timeout_q;
`else
  assign err_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_weather_feature_sequencer.sv
// Self-checking bench for weather_feature_sequencer: table vectors, hand-written corner sequences
// and randomized beats checked against an arithmetic reference model.
module tb_weather_feature_sequencer;

  localparam int HOLD         = 8;
  localparam int TEMP_OFFSET  = 8;
  localparam int TEMP_SHIFT   = 2;
  localparam int PRECIP_SHIFT = 0;
  localparam int WIND_SHIFT   = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_temp_max, in_temp_min, in_precipitation, in_wind;
  logic       feat_valid, tree_rst, vec_done, err_timeout;
  logic [7:0] vec_count;

  weather_feature_sequencer_if rif();

  weather_feature_sequencer #(
    .TEMP_OFFSET (TEMP_OFFSET),
    .TEMP_SHIFT  (TEMP_SHIFT),
    .PRECIP_SHIFT(PRECIP_SHIFT),
    .WIND_SHIFT  (WIND_SHIFT),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .CLOCK_50        (clk),
    .rst             (rst),
    .raw             (rif),
    .in_temp_max     (in_temp_max),
    .in_temp_min     (in_temp_min),
    .in_precipitation(in_precipitation),
    .in_wind         (in_wind),
    .feat_valid      (feat_valid),
    .tree_rst        (tree_rst),
    .vec_done        (vec_done),
    .vec_count       (vec_count),
    .err_timeout     (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][7:0] d;
    logic [3:0][3:0] e;
  } vec_t;

  vec_t tbl [7];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_feat [4];
  int   m_mask = 0;
  int   exp_count = 0;
  int   exp_done_total = 0;
  int   exp_to = 0;
  int   vd_pulses = 0;
  int   to_pulses = 0;

  // Pulse counters sample at the rising edge, i.e. the value held during the cycle just ending.
  always @(posedge clk) begin
    if (vec_done)    vd_pulses <= vd_pulses + 1;
    if (err_timeout) to_pulses <= to_pulses + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int q_model(input int field, input int data8);
    int t;
    int v;
    if (field < 2) begin
      t = ((data8 > 127) ? data8 - 256 : data8) + TEMP_OFFSET;
      v = (t < 0) ? 0 : t / (2 ** TEMP_SHIFT);
    end else begin
      v = data8 / (2 ** ((field == 2) ? PRECIP_SHIFT : WIND_SHIFT));
    end
    return (v > 15) ? 15 : v;
  endfunction

  function automatic logic [15:0] feat_act();
    return {in_wind, in_precipitation, in_temp_min, in_temp_max};
  endfunction

  function automatic logic [15:0] model_feats();
    return {4'(m_feat[3]), 4'(m_feat[2]), 4'(m_feat[1]), 4'(m_feat[0])};
  endfunction

  // Starts and ends on a falling edge; returns in the cycle right after acceptance.
  task automatic send_beat(input int field, input int data, output bit ok);
    int waited;
    bit rdy;
    waited = 0;
    ok = 1'b0;
    rif.raw_valid = 1'b1;
    rif.raw_field = 2'(field);
    rif.raw_data  = 8'(data);
    while (!ok && waited < 50) begin
      rdy = rif.raw_ready;
      @(posedge clk);
      @(negedge clk);
      waited++;
      if (rdy) ok = 1'b1;
    end
    rif.raw_valid = 1'b0;
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  // Cycle k=1 is the cycle after the completing beat; runs through k=HOLD+2.
  task automatic check_window(input string name);
    logic [31:0] fv, tr, vd, rr;
    logic [15:0] f0;
    int          changes;
    fv = '0; tr = '0; vd = '0; rr = '0; changes = 0;
    f0 = feat_act();
    for (int k = 1; k <= HOLD + 2; k++) begin
      if (k > 1) @(negedge clk);
      fv = fv | (32'(feat_valid) << k);
      tr = tr | (32'(tree_rst) << k);
      vd = vd | (32'(vec_done) << k);
      rr = rr | (32'(rif.raw_ready) << k);
      if (k <= HOLD && feat_act() != f0) changes++;
    end
    chk({name, "_feat_valid"}, 64'(fv), 64'(((32'd1 << HOLD) - 32'd1) << 1));
    chk({name, "_tree_rst"},   64'(tr), 64'd2);
    chk({name, "_vec_done"},   64'(vd), 64'(32'd1 << (HOLD + 1)));
    chk({name, "_raw_ready"},  64'(rr), 64'(32'd1 << (HOLD + 2)));
    chk({name, "_stable"},     64'(changes), 64'd0);
  endtask

  task automatic beat(input int field, input int data, input bit hold_after = 1'b0,
                      input string name = "vec");
    bit ok;
    bit complete;
    send_beat(field, data, ok);
    if (ok) begin
      m_feat[field] = q_model(field, data);
      m_mask = m_mask | (1 << field);
    end
    complete = (m_mask == 15);
    chk("features", 64'(feat_act()), 64'(model_feats()));
    chk("feat_valid", 64'(feat_valid), 64'(complete));
    if (complete) begin
      if (hold_after) begin
        rif.raw_valid = 1'b1;
        rif.raw_field = 2'd0;
        rif.raw_data  = 8'd0;
      end
      check_window(name);
      m_mask = 0;
      exp_count = (exp_count + 1) % 256;
      exp_done_total++;
      chk("vec_count", 64'(vec_count), 64'(exp_count));
    end
  endtask

  task automatic set_vec(input int i, input int tmax, input int tmin, input int p, input int w,
                         input int etmax, input int etmin, input int ep, input int ew);
    tbl[i].d = {8'(w), 8'(p), 8'(tmin), 8'(tmax)};
    tbl[i].e = {4'(ew), 4'(ep), 4'(etmin), 4'(etmax)};
  endtask

  function automatic void model_reset();
    for (int f = 0; f < 4; f++) m_feat[f] = 0;
    m_mask = 0;
    exp_count = 0;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          vd0;
    int          t0;
    logic [31:0] pat;

    rif.raw_valid = 1'b0;
    rif.raw_field = 2'd0;
    rif.raw_data  = 8'd0;
    rst = 1'b1;
    model_reset();

    set_vec(0,   20,  -20,   3,   9,   7,  0,  3,  4);
    set_vec(1,  127, -128, 200, 255,  15,  0, 15, 15);
    set_vec(2,   -8,   -9,  15,  30,   0,  0, 15, 15);
    set_vec(3,   51,   52,  16,  31,  14, 15, 15, 15);
    set_vec(4,   -5,    0,   0,   1,   0,  2,  0,  0);
    set_vec(5,    4,   -4,   7,   2,   3,  1,  7,  1);
    set_vec(6,  -50,   60,  14,  29,   0, 15, 14, 14);

    // Reset state, then IDLE for one cycle before COLLECT.
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({rif.raw_ready, feat_valid, tree_rst, vec_done, err_timeout,
                              vec_count, feat_act()}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_idle", 64'(rif.raw_ready), 64'd1);

    for (int i = 0; i < 7; i++) begin
      for (int f = 0; f < 4; f++) beat(f, int'(tbl[i].d[f]), 1'b0, "table");
      chk("table_features", 64'(feat_act()), 64'(tbl[i].e));
    end

    // Duplicate field overwrites but does not advance the mask.
    beat(0, 20);
    beat(0, 40);
    beat(1, 0);
    beat(2, 0);
    chk("dup_temp_max", 64'(in_temp_max), 64'd12);
    chk("dup_no_present", 64'(feat_valid), 64'd0);
    beat(3, 0, 1'b0, "dup");

    // Back-pressure: a beat offered throughout PRESENT waits for COLLECT.
    beat(1, 5);
    beat(2, 5);
    beat(3, 5);
    beat(0, 20, 1'b1, "bp");
    chk("bp_not_taken_early", 64'(in_temp_max), 64'd7);
    @(posedge clk);
    @(negedge clk);
    rif.raw_valid = 1'b0;
    m_feat[0] = 2;
    m_mask = 1;
    chk("bp_accepted", 64'(in_temp_max), 64'd2);
    beat(1, 236);
    beat(2, 1);
    beat(3, 1, 1'b0, "bp_fill");

`ifdef WEATHER_FEATURE_SEQ_TIMEOUT_EN
    t0 = to_pulses;
    repeat (20) @(negedge clk);
    chk("empty_no_timeout", 64'(to_pulses - t0), 64'd0);
    beat(0, 20);
    pat = '0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      pat = pat | (32'(err_timeout) << k);
    end
    chk("timeout_pulse", 64'(pat), 64'(32'd1 << 17));
    m_mask = 0;
    exp_to++;
    beat(1, 10);
    beat(2, 10);
    beat(3, 10);
    beat(0, 10, 1'b0, "after_timeout");
`else
    t0 = 0;
    pat = '0;
`endif

    // Reset mid-collect discards the partial vector.
    beat(0, 30);
    beat(1, 10);
    beat(2, 50);
    vd0 = vd_pulses;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outputs", 64'({feat_act(), feat_valid, rif.raw_ready, vec_count}), 64'd0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("midrst_ready", 64'(rif.raw_ready), 64'd1);
    beat(1, 10);
    beat(2, 10);
    beat(3, 10);
    repeat (5) @(negedge clk);
    chk("midrst_wait_valid", 64'(feat_valid), 64'd0);
    chk("midrst_no_done", 64'(vd_pulses - vd0), 64'd0);
    beat(0, 100, 1'b0, "midrst");

    // Randomized beats with idle gaps against the reference model.
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      beat(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 1'b0, "rand");
    end

    repeat (3) @(negedge clk);
    chk("total_vec_done", 64'(vd_pulses), 64'(exp_done_total));
    chk("total_err_timeout", 64'(to_pulses), 64'(exp_to));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/weather_feature_sequencer.md
# weather_feature_sequencer

Producer side of the classifier feature interface. Accepts raw sensor readings one field per handshake beat and quantizes each to a saturating 4-bit bin. Assembles a complete four-field feature vector and presents it stable to the decision tree for a fixed window. Pulses the tree's reset so each vector is classified from the root node.

## Interface
Parameters:
- TEMP_OFFSET, 8: signed bias added to raw temperature before scaling
- TEMP_SHIFT, 2: right shift applied to biased temperature
- PRECIP_SHIFT, 0: right shift applied to raw precipitation
- WIND_SHIFT, 1: right shift applied to raw wind
- HOLD_CYCLES, 8: cycles feat_valid stays high per vector (min 2, max 255)
- TIMEOUT, 16: idle-cycle limit for a partial vector (used only with the macro)

Ports:
- CLOCK_50  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- raw_valid  in  1  raw beat offered
- raw_ready  out  1  sequencer can accept a beat
- raw_field  in  2  field select: 0 temp_max, 1 temp_min, 2 precipitation, 3 wind
- raw_data  in  8  temps are signed °C; precipitation and wind are unsigned
- in_temp_max, in_temp_min, in_precipitation, in_wind  out  4 each  quantized features to the tree
- feat_valid  out  1  features stable and under classification
- tree_rst  out  1  one-cycle reset pulse to the tree
- vec_done  out  1  one-cycle pulse when the presentation window ends
- vec_count  out  8  completed-vector count, wraps 255 -> 0
- err_timeout  out  1  one-cycle pulse when a partial vector is discarded

## Operation
- A beat is accepted on a rising edge with raw_valid && raw_ready.
- Temperature quantization:
  - compute s = raw_data (sign-extended to 10 bits) + TEMP_OFFSET
  - if s < 0, result is 0
  - otherwise result is min(s >> TEMP_SHIFT, 15)
- Precipitation and wind quantization: min(raw_data >> SHIFT, 15), unsigned.
- The quantized value is written into the selected feature register. A 4-bit received mask sets the bit for that field.
- A duplicate field overwrites the stored value. The mask is unchanged.
- No cross-field checks. temp_min > temp_max is passed through as-is.
- FSM states: IDLE, COLLECT, PRESENT, DONE.
  - IDLE: reset state, lasts 1 cycle, raw_ready=0. Always moves to COLLECT.
  - COLLECT: raw_ready=1. Moves to PRESENT when the accepted beat completes the mask (mask | new bit == 4'b1111).
  - PRESENT: raw_ready=0, feat_valid=1. tree_rst=1 in the first PRESENT cycle only. A hold counter runs HOLD_CYCLES cycles, then the FSM moves to DONE.
  - DONE: 1 cycle. vec_done=1, feat_valid=0, raw_ready=0, vec_count increments, mask clears. Then COLLECT.
- Feature outputs keep their last values outside PRESENT. They are overwritten only by accepted beats.
- raw_valid during PRESENT or DONE is back-pressured. The beat stays pending and is accepted in the first COLLECT cycle.

## Timing
- All outputs are registered.
- Reset values: raw_ready, feat_valid, tree_rst, vec_done and err_timeout are 0. All features are 0, vec_count is 0, the mask is clear, and the state is IDLE.
- raw_ready first goes high 2 cycles after the rst sample that deasserts it (IDLE, then COLLECT).
- Beat accepted at edge T: the feature output is updated and visible from T+1.
- Completing beat at edge T:
  - feat_valid=1 and tree_rst=1 in cycle T+1
  - feat_valid stays high through cycle T+HOLD_CYCLES
  - vec_done=1 in cycle T+HOLD_CYCLES+1
  - raw_ready=1 again from T+HOLD_CYCLES+2
- Minimum vector period: 4 + HOLD_CYCLES + 1 cycles.
- rst mid-operation (any state) aborts immediately:
  - the mask clears and the partial or presented vector is lost
  - vec_count is not incremented and vec_done does not pulse

## Configuration
- Macro: WEATHER_FEATURE_SEQ_TIMEOUT_EN.
- Defined:
  - In COLLECT with a non-empty mask, an idle counter counts cycles with no accepted beat.
  - Every accepted beat resets the counter.
  - When the counter reaches TIMEOUT, the mask clears and err_timeout pulses for 1 cycle. Feature outputs keep their values and the state stays COLLECT.
  - An empty mask never times out.
- Undefined: a partial vector waits indefinitely, err_timeout is tied 0, and there is no idle counter logic.

## Test plan
- Basic vector: temp_max=20, temp_min=-20, precip=3, wind=9 on consecutive cycles.
  - Expect features 7, 0, 3, 4.
  - tree_rst 1 cycle; feat_valid exactly 8 cycles.
  - vec_done the cycle after; vec_count=1.
- Saturation: temp_max=127 -> 15; temp_min=-128 -> 0; precip=200 -> 15; wind=255 -> 15.
- Duplicate field: temp_max=20 then temp_max=40.
  - No PRESENT until temp_min, precip and wind all arrive.
  - in_temp_max=12.
- Back-pressure: hold raw_valid=1 (field 0, data 0) throughout PRESENT.
  - raw_ready=0 for 9 cycles.
  - The beat is accepted on the first COLLECT cycle, and in_temp_max becomes 2.
- Reset mid-collect: 3 fields, then rst for 1 cycle.
  - All features 0 and no vec_done.
  - A fresh 4 fields are required before feat_valid rises.
- With WEATHER_FEATURE_SEQ_TIMEOUT_EN and TIMEOUT=16: 1 beat, then 16 idle cycles.
  - err_timeout pulses once.
  - 4 further beats are then required for PRESENT.
